tiny_alu_mc: RTL and testbench
==============================

Name: tiny_alu_mc

Overview:
- Parametrised successor of tiny_alu: multi-cycle ALU with width-generic operands, configurable multiply latency, a SUB opcode and an explicit busy_o back-pressure output.
- Sits behind the tiny_alu BFM/driver in the layered TB and is the DUT for the next TB generation.
- Single-cycle ops may issue back-to-back; MUL blocks further issue until it completes.

Parameters:
- INPUT_DATA_BITS, 8, operand width; result width is 2*INPUT_DATA_BITS.
- MUL_LATENCY, 3, cycles from MUL acceptance to done_o; legal range 2..16, elaboration error outside it.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous reset, active low.
- a_i  in  INPUT_DATA_BITS  operand A.
- b_i  in  INPUT_DATA_BITS  operand B.
- opcode_i  in  OPCODE_BITS(3)  operation select.
- start_i  in  1  issue request.
- busy_o  out  1  high while a MUL is in flight; start_i is ignored while high.
- result_o  out  2*INPUT_DATA_BITS  result; held until the next done_o.
- done_o  out  1  one-cycle pulse, result_o valid.

Behaviour:
- Interface: one clock, clk_i; reset_n_i is synchronous and active low.
- Reset: result_o=0, done_o=0, busy_o=0, state IDLE, MUL counter=0.
- Reset mid-MUL aborts the operation; no done_o is produced.
- Opcodes:
  - 0 NOP.
  - 1 ADD: zero-extended a+b.
  - 2 AND: zero-extended.
  - 3 XOR: zero-extended.
  - 4 MUL: unsigned full product.
  - 5 SUB: (a-b) mod 2^(2*INPUT_DATA_BITS), so it sign-extends into the full width.
  - 6-7 reserved.
- Acceptance: on a rising edge with state IDLE and start_i=1; a_i, b_i and opcode_i are captured on that edge.
- Latency L: done_o is high in the L-th cycle after the acceptance edge.
  - L=1 for ADD/AND/XOR/SUB.
  - L=MUL_LATENCY for MUL.
- NOP and reserved opcodes: accepted, no done_o, result_o unchanged, busy_o stays 0.
- States:
  - IDLE: start with a single-cycle op registers result_o/done_o and stays IDLE, so issue every cycle is possible. Start with MUL goes to MULT with cnt=MUL_LATENCY-1.
  - MULT: busy_o=1, cnt decrements each edge. On the edge where cnt==1, result_o and done_o are registered and the state returns to IDLE.
- busy_o is high in cycles 1..MUL_LATENCY-1 after MUL acceptance and low in the done cycle, so a new start is accepted in the MUL done cycle.
- start_i while busy_o=1 is dropped silently; operands are not re-sampled.
- done_o deasserts the cycle after its pulse unless another single-cycle op was accepted on the done edge.

Optional Feature:
- Macro: TINY_ALU_MC_ERR_EN.
- Defined: adds port err_o (out, 1). Reserved opcodes 6-7 behave as single-cycle ops: done_o=1, err_o=1, result_o=0 at L=1. err_o is 0 with every other done_o, and resets to 0.
- Undefined: no err_o port; reserved opcodes behave as NOP.

Decomposition:
- tiny_alu_pkg holds:
  - OPCODE_BITS=3.
  - opcode_e enum (NOP, ADD, AND, XOR, MUL, SUB).
  - alu_state_e enum (IDLE, MULT).
  - MUL_LATENCY_MIN=2 and MUL_LATENCY_MAX=16.
- Sub-module tiny_alu_mc_mult holds the operand capture register, the product register and the latency counter. It has start and done ports; the top keeps the opcode decode and the single-cycle datapath.

Test Plan (INPUT_DATA_BITS=8, MUL_LATENCY=3):
- ADD a=0xFF b=0x01 -> cycle 1: done_o=1, result_o=0x0100, busy_o=0.
- SUB a=0x01 b=0x02, then XOR a=0xF0 b=0x3C on the next cycle -> consecutive done pulses, result_o=0xFFFF then 0x00CC.
- MUL a=0xFF b=0xFF -> busy_o=1 in cycles 1-2, done_o=1 with result_o=0xFE01 in cycle 3.
- MUL 0x02*0x03 with ADD start_i asserted in cycle 1 -> ADD dropped; single done in cycle 3 with 0x0006. ADD issued in cycle 3 -> done in cycle 4.
- reset_n_i=0 in cycle 1 of a MUL -> outputs 0, no done_o; next ADD 0x01+0x01 -> 0x0002 at L=1.
- NOP and opcode 7 -> no done_o, result_o unchanged. With TINY_ALU_MC_ERR_EN, opcode 7 -> done_o=1, err_o=1, result_o=0.

Source files
------------

// File: rtl/tiny_alu_pkg.sv
// tiny_alu_pkg -- shared types and constants for the tiny_alu_mc block.
//   OPCODE_BITS      : width of the opcode field.
//   opcode_e         : operation encodings (6-7 are reserved).
//   alu_state_e      : top-level issue state.
//   MUL_LATENCY_MIN/MAX : legal range for the multiply latency parameter.
package tiny_alu_pkg;

    localparam int OPCODE_BITS     = 3;
    localparam int MUL_LATENCY_MIN = 2;
    localparam int MUL_LATENCY_MAX = 16;
    // Wide enough to hold MUL_LATENCY_MAX-1.
    localparam int MUL_CNT_BITS    = $clog2(MUL_LATENCY_MAX);

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4,
        OP_SUB = 3'd5
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } alu_state_e;

endpackage

// File: rtl/tiny_alu_mc_if.sv
// tiny_alu_mc_if -- issue/result bus of tiny_alu_mc.
//   a_i, b_i   : operands (INPUT_DATA_BITS)
//   opcode_i   : operation select (OPCODE_BITS)
//   start_i    : issue request
//   busy_o     : MUL in flight, start_i ignored
//   result_o   : result (2*INPUT_DATA_BITS), held until next done_o
//   done_o     : one-cycle result-valid pulse
//   err_o      : reserved-opcode flag, only with TINY_ALU_MC_ERR_EN defined
// master = requester side, slave = the ALU.
interface tiny_alu_mc_if #(
    parameter int INPUT_DATA_BITS = 8
);
    import tiny_alu_pkg::*;

    logic [INPUT_DATA_BITS-1:0]   a_i;
    logic [INPUT_DATA_BITS-1:0]   b_i;
    logic [OPCODE_BITS-1:0]       opcode_i;
    logic                         start_i;
    logic                         busy_o;
    logic [2*INPUT_DATA_BITS-1:0] result_o;
    logic                         done_o;
`ifdef TINY_ALU_MC_ERR_EN
    logic                         err_o;
`endif

    modport master (
        output a_i, b_i, opcode_i, start_i,
        input  busy_o, result_o, done_o
`ifdef TINY_ALU_MC_ERR_EN
        , input err_o
`endif
    );

    modport slave (
        input  a_i, b_i, opcode_i, start_i,
        output busy_o, result_o, done_o
`ifdef TINY_ALU_MC_ERR_EN
        , output err_o
`endif
    );

endinterface

// File: rtl/tiny_alu_mc_mult.sv
// tiny_alu_mc_mult -- multi-cycle unsigned multiplier for tiny_alu_mc.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   start_i          : accept a MUL; captures a_i/b_i and loads the counter
//   a_i, b_i         : operands (W bits)
//   last_o           : counter is on its final edge (product registers now)
//   done_o           : registered pulse, prod_o valid this cycle
//   prod_o           : product register (2*W), held until the next MUL
// The counter is loaded with LAT-1 on acceptance; the product and done
// are registered on the edge where it reads 1, so done_o lands LAT cycles
// after the acceptance edge.
module tiny_alu_mc_mult
    import tiny_alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int LAT = 3
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           last_o,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);

    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [MUL_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]          prod_q, prod_d;
    logic                    done_q, done_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        done_d = 1'b0;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            cnt_d = MUL_CNT_BITS'(LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q == MUL_CNT_BITS'(1)) begin
            prod_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
            done_q <= done_d;
        end
    end

    assign last_o = (cnt_q == MUL_CNT_BITS'(1));
    assign done_o = done_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/tiny_alu_mc.sv
// tiny_alu_mc -- multi-cycle ALU: ADD/AND/XOR/SUB in one cycle, MUL in
// MUL_LATENCY cycles with busy_o back-pressure.
//   clk_i      : clock
//   reset_n_i  : synchronous reset, active low
//   bus        : tiny_alu_mc_if.slave (a_i, b_i, opcode_i, start_i,
//                busy_o, result_o, done_o [, err_o])
// Optional feature: TINY_ALU_MC_ERR_EN adds err_o and turns reserved
// opcodes 6-7 into single-cycle error completions with result 0.
module tiny_alu_mc
    import tiny_alu_pkg::*;
#(
    parameter int INPUT_DATA_BITS = 8,
    parameter int MUL_LATENCY     = 3
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    tiny_alu_mc_if.slave  bus
);

    localparam int W  = INPUT_DATA_BITS;
    localparam int RW = 2 * INPUT_DATA_BITS;

    if (MUL_LATENCY < MUL_LATENCY_MIN || MUL_LATENCY > MUL_LATENCY_MAX) begin : g_bad_latency
        $error("tiny_alu_mc: MUL_LATENCY out of range 2..16");
    end

    alu_state_e    state_q;
    logic [RW-1:0] alu_res_q;
    logic          alu_done_q;
    logic          err_q;
    // Selects which register currently owns result_o: the MUL product
    // or the single-cycle result. Flips only when an op completes, so
    // result_o holds across NOPs and dropped starts.
    logic          src_mul_q;

    logic          accept;
    logic          mul_start;
    logic          mul_last;
    logic          mul_done;
    logic [RW-1:0] mul_prod;

    // start_i is only looked at in IDLE, which is how starts during a
    // MUL get dropped without re-sampling operands.
    assign accept    = (state_q == ST_IDLE) && bus.start_i;
    assign mul_start = accept && (bus.opcode_i == OP_MUL);

    tiny_alu_mc_mult #(
        .W   (W),
        .LAT (MUL_LATENCY)
    ) u_mult (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (mul_start),
        .a_i       (bus.a_i),
        .b_i       (bus.b_i),
        .last_o    (mul_last),
        .done_o    (mul_done),
        .prod_o    (mul_prod)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            alu_res_q  <= '0;
            alu_done_q <= 1'b0;
            err_q      <= 1'b0;
            src_mul_q  <= 1'b0;
        end else begin
            alu_done_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.opcode_i)
                            OP_NOP: ;
                            OP_ADD: begin
                                alu_res_q  <= RW'(bus.a_i) + RW'(bus.b_i);
                                alu_done_q <= 1'b1;
                                src_mul_q  <= 1'b0;
                            end
                            OP_AND: begin
                                alu_res_q  <= RW'(bus.a_i & bus.b_i);
                                alu_done_q <= 1'b1;
                                src_mul_q  <= 1'b0;
                            end
                            OP_XOR: begin
                                alu_res_q  <= RW'(bus.a_i ^ bus.b_i);
                                alu_done_q <= 1'b1;
                                src_mul_q  <= 1'b0;
                            end
                            // Full-width subtract: a borrow fills the upper half.
                            OP_SUB: begin
                                alu_res_q  <= RW'(bus.a_i) - RW'(bus.b_i);
                                alu_done_q <= 1'b1;
                                src_mul_q  <= 1'b0;
                            end
                            OP_MUL: state_q <= ST_MULT;
`ifdef TINY_ALU_MC_ERR_EN
                            default: begin
                                alu_res_q  <= '0;
                                alu_done_q <= 1'b1;
                                err_q      <= 1'b1;
                                src_mul_q  <= 1'b0;
                            end
`else
                            default: ;
`endif
                        endcase
                    end
                end
                ST_MULT: begin
                    // The multiplier registers its product on this same
                    // edge, so the mux can switch over now.
                    if (mul_last) begin
                        state_q   <= ST_IDLE;
                        src_mul_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state_q == ST_MULT);
    assign bus.done_o   = alu_done_q | mul_done;
    assign bus.result_o = src_mul_q ? mul_prod : alu_res_q;
`ifdef TINY_ALU_MC_ERR_EN
    assign bus.err_o    = err_q;
`endif

endmodule

// File: tb/tb_tiny_alu_mc.sv
// tb_tiny_alu_mc -- self-checking bench for tiny_alu_mc (8-bit, MUL_LATENCY=3).
// A cycle-level reference model tracks expected result/done/busy from the
// operation rules; directed tasks also check literal values.
module tb_tiny_alu_mc;

    localparam int N = 8;
    localparam int L = 3;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    tiny_alu_mc_if #(.INPUT_DATA_BITS(N)) bif ();

    tiny_alu_mc #(
        .INPUT_DATA_BITS (N),
        .MUL_LATENCY     (L)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [2*N-1:0] m_result;
    logic [2*N-1:0] m_mul_val;
    logic           m_done;
    logic           m_err;
    int             m_wait;   // cycles until the pending MUL completes

    function automatic void model_step(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] op, input logic st, input logic rn);
        logic [2*N-1:0] wa, wb;
        wa     = {{N{1'b0}}, a};
        wb     = {{N{1'b0}}, b};
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rn) begin
            m_result = '0;
            m_wait   = 0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_result = m_mul_val;
                m_done   = 1'b1;
            end
        end else if (st) begin
            case (op)
                3'd1: begin m_result = wa + wb; m_done = 1'b1; end
                3'd2: begin m_result = wa & wb; m_done = 1'b1; end
                3'd3: begin m_result = wa ^ wb; m_done = 1'b1; end
                3'd4: begin m_mul_val = wa * wb; m_wait = L - 1; end
                3'd5: begin m_result = wa - wb; m_done = 1'b1; end
`ifdef TINY_ALU_MC_ERR_EN
                3'd6, 3'd7: begin m_result = '0; m_done = 1'b1; m_err = 1'b1; end
`endif
                default: ;
            endcase
        end
    endfunction

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] op, input logic st, input logic rn);
        bif.a_i      = a;
        bif.b_i      = b;
        bif.opcode_i = op;
        bif.start_i  = st;
        rst_n        = rn;
        @(posedge clk);
        #1;
        model_step(a, b, op, st, rn);
    endtask

    task automatic test_reset();
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        vectors++;
        if (bif.result_o !== 16'h0000) begin miscompares++; $display("FAIL reset_result got %h want 0000", bif.result_o); end
        vectors++;
        if (bif.done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bif.done_o); end
        vectors++;
        if (bif.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bif.busy_o); end
`ifdef TINY_ALU_MC_ERR_EN
        vectors++;
        if (bif.err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bif.err_o); end
`endif
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_add();
        apply(8'hFF, 8'h01, 3'd1, 1'b1, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'h0100 || bif.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL add_ff_01 got done=%b res=%h busy=%b want 1 0100 0", bif.done_o, bif.result_o, bif.busy_o);
        end
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b0 || bif.result_o !== 16'h0100) begin
            miscompares++;
            $display("FAIL add_hold got done=%b res=%h want 0 0100", bif.done_o, bif.result_o);
        end
    endtask

    task automatic test_back_to_back();
        apply(8'h01, 8'h02, 3'd5, 1'b1, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL b2b_sub got done=%b res=%h want 1 ffff", bif.done_o, bif.result_o);
        end
        apply(8'hF0, 8'h3C, 3'd3, 1'b1, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'h00CC) begin
            miscompares++;
            $display("FAIL b2b_xor got done=%b res=%h want 1 00cc", bif.done_o, bif.result_o);
        end
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b0) begin miscompares++; $display("FAIL b2b_done_drop got %b want 0", bif.done_o); end
    endtask

    task automatic test_mul();
        apply(8'hFF, 8'hFF, 3'd4, 1'b1, 1'b1);
        for (int c = 1; c < L; c++) begin
            vectors++;
            if (bif.busy_o !== 1'b1 || bif.done_o !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_busy c%0d got busy=%b done=%b want 1 0", c, bif.busy_o, bif.done_o);
            end
            apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        end
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'hFE01 || bif.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_done got done=%b res=%h busy=%b want 1 fe01 0", bif.done_o, bif.result_o, bif.busy_o);
        end
    endtask

    task automatic test_mul_drop();
        apply(8'h02, 8'h03, 3'd4, 1'b1, 1'b1);            // cycle 1
        apply(8'h10, 8'h20, 3'd1, 1'b1, 1'b1);            // ADD while busy -> dropped
        vectors++;
        if (bif.done_o !== 1'b0 || bif.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_c2 got done=%b busy=%b want 0 1", bif.done_o, bif.busy_o);
        end
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);            // cycle 3
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'h0006) begin
            miscompares++;
            $display("FAIL drop_mul got done=%b res=%h want 1 0006", bif.done_o, bif.result_o);
        end
        apply(8'h05, 8'h07, 3'd1, 1'b1, 1'b1);            // ADD issued in done cycle
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'h000C) begin
            miscompares++;
            $display("FAIL drop_add_c4 got done=%b res=%h want 1 000c", bif.done_o, bif.result_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        apply(8'h33, 8'h44, 3'd4, 1'b1, 1'b1);
        apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        vectors++;
        if (bif.done_o !== 1'b0 || bif.busy_o !== 1'b0 || bif.result_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid got done=%b busy=%b res=%h want 0 0 0000", bif.done_o, bif.busy_o, bif.result_o);
        end
        for (int c = 0; c < L + 1; c++) begin
            apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
            vectors++;
            if (bif.done_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_nodone c%0d got %b want 0", c, bif.done_o); end
        end
        apply(8'h01, 8'h01, 3'd1, 1'b1, 1'b1);
        vectors++;
        if (bif.done_o !== 1'b1 || bif.result_o !== 16'h0002) begin
            miscompares++;
            $display("FAIL rst_mid_add got done=%b res=%h want 1 0002", bif.done_o, bif.result_o);
        end
    endtask

    task automatic test_nop_reserved();
        apply(8'h0F, 8'h0A, 3'd2, 1'b1, 1'b1);            // AND -> 000a
        apply(8'hAA, 8'h55, 3'd0, 1'b1, 1'b1);            // NOP
        vectors++;
        if (bif.done_o !== 1'b0 || bif.result_o !== 16'h000A || bif.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL nop got done=%b res=%h busy=%b want 0 000a 0", bif.done_o, bif.result_o, bif.busy_o);
        end
        apply(8'hAA, 8'h55, 3'd7, 1'b1, 1'b1);
`ifdef TINY_ALU_MC_ERR_EN
        vectors++;
        if (bif.done_o !== 1'b1 || bif.err_o !== 1'b1 || bif.result_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL op7_err got done=%b err=%b res=%h want 1 1 0000", bif.done_o, bif.err_o, bif.result_o);
        end
        apply(8'h01, 8'h02, 3'd1, 1'b1, 1'b1);
        vectors++;
        if (bif.err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bif.err_o); end
`else
        vectors++;
        if (bif.done_o !== 1'b0 || bif.result_o !== 16'h000A || bif.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL op7_nop got done=%b res=%h busy=%b want 0 000a 0", bif.done_o, bif.result_o, bif.busy_o);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic rn, st;
            rn = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) != 0);
            apply(N'($urandom), N'($urandom), 3'($urandom_range(0, 7)), st, rn);
            vectors++;
            if (bif.done_o !== m_done || bif.result_o !== m_result || bif.busy_o !== (m_wait > 0)) begin
                miscompares++;
                $display("FAIL rand[%0d] got done=%b res=%h busy=%b want %b %h %b",
                         i, bif.done_o, bif.result_o, bif.busy_o, m_done, m_result, (m_wait > 0));
            end
`ifdef TINY_ALU_MC_ERR_EN
            vectors++;
            if (bif.err_o !== m_err) begin
                miscompares++;
                $display("FAIL rand_err[%0d] got %b want %b", i, bif.err_o, m_err);
            end
`endif
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        m_result     = '0;
        m_mul_val    = '0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        m_wait       = 0;
        rst_n        = 1'b0;
        bif.a_i      = '0;
        bif.b_i      = '0;
        bif.opcode_i = '0;
        bif.start_i  = 1'b0;

        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_mul_drop();
        test_reset_mid_mul();
        test_nop_reserved();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
